// File: rtl/ecc_mont_sequencer.sv
// Job sequencer for one ECC point operation: to-Montgomery conversion, engine run,
// back-conversion, then result presentation. Drives all TDU/engine handshakes.
module ecc_mont_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] Px_i,
  input  logic [WIDTH-1:0] Py_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] Prime_i,
  output logic             dt_in_sig,
  output logic             dt_ToMont,
  output logic [WIDTH-1:0] dt_Px,
  output logic [WIDTH-1:0] dt_Py,
  output logic [WIDTH-1:0] dt_A,
  output logic [WIDTH-1:0] dt_Prime,
  input  logic             dt_done,
  input  logic [WIDTH-1:0] dt_Px_o,
  input  logic [WIDTH-1:0] dt_Py_o,
  input  logic [WIDTH-1:0] dt_A_o,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_Px,
  output logic [WIDTH-1:0] eng_Py,
  output logic [WIDTH-1:0] eng_A,
  output logic [WIDTH-1:0] eng_Prime,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_Rx,
  input  logic [WIDTH-1:0] eng_Ry,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] Rx_o,
  output logic [WIDTH-1:0] Ry_o,
  output logic [WIDTH-1:0] A_o
);

  typedef enum logic [3:0] {
    IDLE, TM_REQ, TM_WAIT, TM_CAP, ENG_REQ, ENG_WAIT,
    TR_REQ, TR_WAIT, TR_CAP, DONE, ERR
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] px_reg, py_reg, a_reg, prime_reg;
  logic [WIDTH-1:0] mpx_reg, mpy_reg, ma_reg;
  logic [WIDTH-1:0] erx_reg, ery_reg;
  logic [WIDTH-1:0] rx_reg, ry_reg, ao_reg;
  logic [TW-1:0]    tmo_reg;

  logic load_in, load_mont, load_eng, load_out;
  logic prime_bad, is_wait, timed_out, tr_phase;

  assign prime_bad = ~Prime_i[0] || (Prime_i < WIDTH'(3));
  assign is_wait   = (state_reg == TM_WAIT) || (state_reg == ENG_WAIT) || (state_reg == TR_WAIT);
  assign timed_out = (tmo_reg == TW'(TIMEOUT - 1));
  assign tr_phase  = (state_reg == TR_REQ) || (state_reg == TR_WAIT) || (state_reg == TR_CAP);

  always_comb begin
    state_next = state_reg;
    load_in    = 1'b0;
    load_mont  = 1'b0;
    load_eng   = 1'b0;
    load_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (prime_bad) begin
            state_next = ERR;
          end else begin
            load_in    = 1'b1;
            state_next = TM_REQ;
          end
        end
      end
      TM_REQ:  state_next = TM_WAIT;
      TM_WAIT: begin
        if (dt_done)        state_next = TM_CAP;
        else if (timed_out) state_next = ERR;
      end
      TM_CAP: begin
        load_mont  = 1'b1;
        state_next = ENG_REQ;
      end
      ENG_REQ:  state_next = ENG_WAIT;
      ENG_WAIT: begin
        if (eng_done) begin
          load_eng   = 1'b1;
          state_next = TR_REQ;
        end else if (timed_out) begin
          state_next = ERR;
        end
      end
      TR_REQ:  state_next = TR_WAIT;
      TR_WAIT: begin
        if (dt_done)        state_next = TR_CAP;
        else if (timed_out) state_next = ERR;
      end
      TR_CAP: begin
        load_out   = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      px_reg    <= '0;
      py_reg    <= '0;
      a_reg     <= '0;
      prime_reg <= '0;
      mpx_reg   <= '0;
      mpy_reg   <= '0;
      ma_reg    <= '0;
      erx_reg   <= '0;
      ery_reg   <= '0;
      rx_reg    <= '0;
      ry_reg    <= '0;
      ao_reg    <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Counter is held at zero outside WAIT states, so every WAIT entry starts fresh.
      tmo_reg   <= is_wait ? tmo_reg + TW'(1) : '0;
      if (load_in) begin
        px_reg    <= Px_i;
        py_reg    <= Py_i;
        a_reg     <= A_i;
        prime_reg <= Prime_i;
      end
      if (load_mont) begin
        mpx_reg <= dt_Px_o;
        mpy_reg <= dt_Py_o;
        ma_reg  <= dt_A_o;
      end
      if (load_eng) begin
        erx_reg <= eng_Rx;
        ery_reg <= eng_Ry;
      end
      if (load_out) begin
        rx_reg <= dt_Px_o;
        ry_reg <= dt_Py_o;
        ao_reg <= dt_A_o;
      end
    end
  end

  assign ready     = (state_reg == IDLE);
  assign valid     = (state_reg == DONE);
  assign err       = (state_reg == ERR);
  assign eng_start = (state_reg == ENG_REQ);
  assign dt_in_sig = (state_reg == TM_REQ) || (state_reg == TR_REQ);
  assign dt_ToMont = (state_reg == TM_REQ) || (state_reg == TM_WAIT) || (state_reg == TM_CAP);

  // The back-conversion feeds the engine result and the Montgomery-domain A.
  assign dt_Px    = tr_phase ? erx_reg : px_reg;
  assign dt_Py    = tr_phase ? ery_reg : py_reg;
  assign dt_A     = tr_phase ? ma_reg  : a_reg;
  assign dt_Prime = prime_reg;

  assign eng_Px    = mpx_reg;
  assign eng_Py    = mpy_reg;
  assign eng_A     = ma_reg;
  assign eng_Prime = prime_reg;

  assign Rx_o = rx_reg;
  assign Ry_o = ry_reg;
  assign A_o  = ao_reg;

endmodule

// File: doc/ecc_mont_sequencer.md
Name: ecc_mont_sequencer

Overview:
- Top-level sequencer for one ECC point operation around the shared 32-bit domain-transfer unit (TDU).
- Per job: converts inputs to the Montgomery domain, launches the external point-arithmetic engine, converts the engine result back to the regular domain, then presents it.
- Sits between the host-side job interface and the TDU plus engine.
- Owns all TDU request and capture timing.

Parameters:
- WIDTH, 32, operand width; must equal the TDU width.
- TIMEOUT, 4096, max cycles in any WAIT state before abort; must be ≥ 40.
- TW, 13, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- ready  out  1  high only in IDLE.
- Px_i, Py_i, A_i, Prime_i  in  WIDTH  job operands; captured when start is accepted.
- dt_in_sig  out  1  one-cycle TDU launch pulse.
- dt_ToMont  out  1  TDU direction: 1 = to Montgomery, 0 = to regular.
- dt_Px, dt_Py, dt_A, dt_Prime  out  WIDTH  TDU operands; stable while dt_in_sig is high.
- dt_done  in  1  TDU done; high on the TDU's final iteration cycle.
- dt_Px_o, dt_Py_o, dt_A_o  in  WIDTH  TDU results; valid in the cycle after dt_done.
- eng_start  out  1  one-cycle engine launch pulse.
- eng_Px, eng_Py, eng_A, eng_Prime  out  WIDTH  Montgomery-domain operands to the engine; held from ENG_REQ until the job ends.
- eng_done  in  1  engine done; results valid in the same cycle.
- eng_Rx, eng_Ry  in  WIDTH  engine result, Montgomery domain.
- valid  out  1  one-cycle pulse; Rx_o/Ry_o/A_o are new.
- err  out  1  one-cycle pulse on rejection or timeout.
- Rx_o, Ry_o, A_o  out  WIDTH  regular-domain result; held until the next valid.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE.
  - All registers and outputs = 0, except ready = 1.
  - Applies mid-job: the job is abandoned with no valid and no err.
  - The TDU and engine must share this reset.
- States: IDLE, TM_REQ, TM_WAIT, TM_CAP, ENG_REQ, ENG_WAIT, TR_REQ, TR_WAIT, TR_CAP, DONE, ERR.
- IDLE:
  - On start with Prime_i even or Prime_i < 3: go to ERR. Operands not captured, no TDU pulse.
  - On start otherwise: capture operands, go to TM_REQ.
  - start outside IDLE is ignored.
- TM_REQ: dt_in_sig = 1, dt_ToMont = 1, dt_* = captured operands → TM_WAIT.
- TM_WAIT: stay until dt_done → TM_CAP.
- TM_CAP: latch dt_Px_o/dt_Py_o/dt_A_o into the Montgomery registers → ENG_REQ.
- ENG_REQ: eng_start = 1 → ENG_WAIT.
- ENG_WAIT: on eng_done, latch eng_Rx/eng_Ry → TR_REQ.
- TR_REQ: dt_in_sig = 1, dt_ToMont = 0, dt_Px/dt_Py = engine result, dt_A = Montgomery A → TR_WAIT.
- TR_WAIT: stay until dt_done → TR_CAP.
- TR_CAP: latch TDU outputs into Rx_o/Ry_o/A_o → DONE.
- DONE: valid = 1 → IDLE.
- ERR: err = 1 → IDLE.
- Timeout:
  - Counter clears on entry to each WAIT state and increments each cycle spent in it.
  - Reaching TIMEOUT without the awaited done → ERR.
  - Outputs Rx_o/Ry_o/A_o are unchanged by an abort.
- dt_done or eng_done outside its WAIT state is ignored. dt_in_sig and eng_start are never high simultaneously.
- Latency (start sampled at cycle 0, engine done at cycle 35+L with L ≥ 1):
  - dt_in_sig at cycles 1 and 36+L.
  - dt_done expected at 33 and 68+L.
  - eng_start at 35.
  - valid at 70+L.
  - ready returns at 71+L.
- The second TDU launch is always ≥2 cycles after the first dt_done, so the TDU is back in IDLE.
- Operand reduction (x ≥ Prime) is done by the TDU; the sequencer passes raw operands.
- All data paths are WIDTH bits; no arithmetic beyond the timeout counter.

Test Plan:
- Round trip, real TDU, identity engine (eng_Rx = eng_Px, eng_Ry = eng_Py, L = 5); Px=1, Py=2, A=3, P=13:
  - eng_Px=9, eng_Py=5, eng_A=1 (R = 2^32 mod 13 = 9).
  - valid at cycle 75 with Rx_o=1, Ry_o=2, A_o=3.
- Unreduced input: Px=20, Py=13, A=0, P=13 with identity engine → Rx_o=7, Ry_o=0, A_o=0.
- Bad prime: start with P=12 (then P=1) → err at cycle 1; dt_in_sig never asserted; ready=1 at cycle 2.
- Engine timeout: TIMEOUT=64, eng_done held low → err exactly 64 cycles after ENG_WAIT entry; no valid; next job completes normally.
- start pulsed in TM_WAIT and ENG_WAIT, plus a spurious dt_done in ENG_WAIT → no effect; single valid at 70+L.
- Reset low for one cycle during TR_WAIT → all outputs 0, ready=1 on the next cycle; no valid or err for that job.
